perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Synthesizable, parametrised multi-channel performance counter for the RISC-V microprocessor. It is driven by program start and `HLT` events and counts cycles plus up to `NUM_CH-1` event streams (retired instructions, stalls, flushes, MMIO accesses). It supports snapshot shadow registers, wrap or saturate overflow handling, sticky overflow flags and a registered read port. It sits beside the CPU top level and feeds both the bench and the memory-mapped IO space.

## Interface
- `NUM_CH`, default 4: number of channels, 2..16. Channel 0 is always the cycle counter.
- `CNT_W`, default 32: counter width in bits, 8..64.
- `SATURATE`, default 0: 0 means counters wrap modulo 2^CNT_W; 1 means counters hold at all-ones.
- `clk`  in  1  clock. All state changes on the rising edge.
- `cycle_count_rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  single-cycle pulse: clear all counters and flags, then begin counting.
- `halt`  in  1  level or pulse: stop counting (tied to CPU `HLT`).
- `clear`  in  1  synchronous return to IDLE; zeroes counters, shadows and flags.
- `snap`  in  1  copy all live counters into the shadow registers.
- `evt`  in  NUM_CH  per-channel event strobes. Bit 0 is ignored.
- `rd_sel`  in  $clog2(NUM_CH)  channel to read.
- `rd_shadow`  in  1  0 reads the live counter, 1 reads the shadow.
- `rd_data`  out  CNT_W  registered read data.
- `ovf`  out  NUM_CH  sticky per-channel overflow flags.
- `running`  out  1  high while in RUN.
- `done`  out  1  high while in HALTED.

## Operation
- States:
  - IDLE: counters held.
  - RUN: counting.
  - HALTED: counters frozen, results valid.
- Transitions, in priority order: `clear` (any state) > `start` > `halt`.
  - IDLE + `start` -> RUN. All counters, shadows and `ovf` are set to 0 at that edge.
  - IDLE + `halt` only -> stays IDLE.
  - RUN + `halt` -> HALTED. This takes priority over a simultaneous `start` in RUN.
  - RUN + `start` (no `halt`) -> restart: counters and flags are zeroed, state stays RUN.
  - HALTED + `start` -> RUN, with counters zeroed.
  - Any state + `clear` -> IDLE, with counters, shadows and flags zeroed.
- Counting happens on every edge where the state is RUN and neither `start` nor `clear` is asserted. This includes the edge on which `halt` moves the FSM to HALTED.
  - Channel 0 increments by 1 on every such edge.
  - Channel i>0 increments by 1 when `evt[i]` is sampled high.
- Overflow happens when a counter at 2^CNT_W-1 increments.
  - `SATURATE=0`: the counter becomes 0.
  - `SATURATE=1`: the counter holds at 2^CNT_W-1.
  - In both modes `ovf[i]` sets and stays set until `start`, `clear` or reset.
- Snapshot: on an edge with `snap`, shadow[i] receives the live counter value before that edge's increment. `snap` is honoured in all states. A simultaneous `start` or `clear` zeroes the shadows instead.
- Read: on every edge, `rd_data` <= (`rd_shadow` ? shadow[`rd_sel`] : live[`rd_sel`]), sampled pre-update. If `rd_sel` >= `NUM_CH`, `rd_data` <= 0.

## Timing
- Reset (`cycle_count_rst` high) takes effect immediately, independent of `clk`. While asserted:
  - FSM is IDLE.
  - All counters, shadows, `ovf`, `rd_data` are 0.
  - `running` = 0, `done` = 0.
- Reset deasserted mid-RUN leaves the block in IDLE. No counting occurs until a fresh `start`.
- `running` and `done` are registered state decodes. They change on the same edge as the state.
- Read latency is 1 cycle. A live read returns the value before the increment performed at the same edge.
- Cycle count after a run = number of rising edges from the edge after `start` through the `halt` edge, inclusive.
- No combinational path exists from any input to any output.

## Test plan
- Reset during RUN with channel 0 = 0x1234: all outputs 0 immediately (before any clock edge); after release, 5 edges with no `start` leave channel 0 at 0 and `running`=0.
- `start` pulse, 10 idle edges, then `halt` on edge 11: channel 0 = 11, `done`=1, `running`=0. Extra `halt` cycles do not change the count.
- Channel 1 with `evt[1]` toggling every cycle for 20 RUN cycles: channel 1 = 10. Channel 2 with `evt[2]` held high: channel 2 = 20. `evt[0]` has no effect.
- `CNT_W=8`, `SATURATE=0`, run 257 cycles: channel 0 = 1, `ovf[0]`=1. Same run with `SATURATE=1`: channel 0 = 0xFF, `ovf[0]`=1. A following `start` clears `ovf`.
- `snap` at channel 0 = 7, then run 5 more edges: `rd_shadow`=1, `rd_sel`=0 reads 7 one cycle later; live read returns 12 (sampled while frozen in HALTED after 5 more edges).
- Simultaneous events:
  - `start`+`halt` in IDLE -> RUN.
  - `start`+`halt` in RUN -> HALTED, counts kept.
  - `clear`+`start` -> IDLE, all zero.
  - `rd_sel`=`NUM_CH` -> `rd_data`=0.

Source files
------------

// File: rtl/perf_counter_bank_if.sv
// Control, event and read-port signals of the performance counter bank.
interface perf_counter_bank_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
);
  localparam int unsigned SelW = $clog2(NUM_CH);

  logic              start;
  logic              halt;
  logic              clear;
  logic              snap;
  logic [NUM_CH-1:0] evt;
  logic [SelW-1:0]   rd_sel;
  logic              rd_shadow;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] ovf;
  logic              running;
  logic              done;

  // Driven by the CPU/bench side.
  modport master (
    output start, halt, clear, snap, evt, rd_sel, rd_shadow,
    input  rd_data, ovf, running, done
  );

  // The counter bank itself.
  modport slave (
    input  start, halt, clear, snap, evt, rd_sel, rd_shadow,
    output rd_data, ovf, running, done
  );
endinterface

// File: rtl/perf_counter_bank.sv
// Multi-channel performance counter: channel 0 counts cycles, channels 1.. count
// event strobes. Shadow snapshot registers, wrap/saturate overflow with sticky
// flags, and a one-cycle registered read port.
module perf_counter_bank #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0
) (
  input logic                clk,
  input logic                cycle_count_rst,
  perf_counter_bank_if.slave bus
);
  localparam int unsigned SelW = $clog2(NUM_CH);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic              zero_all;
  logic              count_en;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  shd_q [NUM_CH];
  logic [CNT_W-1:0]  shd_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]  rd_q, rd_d;

  // Next state, plus whether this edge zeroes everything or counts.
  always_comb begin
    state_d  = state_q;
    zero_all = 1'b0;
    count_en = 1'b0;
    if (bus.clear) begin
      state_d  = StIdle;
      zero_all = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d  = StRun;
            zero_all = 1'b1;
          end
        end
        StRun: begin
          if (bus.halt) begin
            // The halt edge still counts, unless start is also present.
            state_d  = StHalted;
            count_en = ~bus.start;
          end else if (bus.start) begin
            zero_all = 1'b1;
          end else begin
            count_en = 1'b1;
          end
        end
        StHalted: begin
          if (bus.start) begin
            state_d  = StRun;
            zero_all = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Counter, shadow and sticky overflow next-state.
  always_comb begin
    cnt_d = cnt_q;
    shd_d = shd_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (zero_all) begin
        cnt_d[i] = '0;
        shd_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else begin
        // Shadow takes the pre-increment value.
        if (bus.snap) shd_d[i] = cnt_q[i];
        if (count_en && ((i == 0) ? 1'b1 : bus.evt[i])) begin
          if (&cnt_q[i]) begin
            ovf_d[i] = 1'b1;
            cnt_d[i] = (SATURATE != 0) ? cnt_q[i] : '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Read mux over pre-update values; out-of-range selects read as zero.
  always_comb begin
    rd_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.rd_sel == SelW'(i)) rd_d = bus.rd_shadow ? shd_q[i] : cnt_q[i];
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge cycle_count_rst) begin
    if (cycle_count_rst) begin
      state_q <= StIdle;
      ovf_q   <= '0;
      rd_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        shd_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      shd_q   <= shd_d;
    end
  end

  assign bus.rd_data = rd_q;
  assign bus.ovf     = ovf_q;
  assign bus.running = (state_q == StRun);
  assign bus.done    = (state_q == StHalted);
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 16-bit wrap instance for functional
// checks plus 8-bit wrap and saturate instances for overflow.
module tb_perf_counter_bank;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  perf_counter_bank_if #(.NUM_CH(3), .CNT_W(16)) a_if ();
  perf_counter_bank_if #(.NUM_CH(3), .CNT_W(8))  b_if ();
  perf_counter_bank_if #(.NUM_CH(3), .CNT_W(8))  c_if ();

  perf_counter_bank #(.NUM_CH(3), .CNT_W(16), .SATURATE(0)) u_a (
    .clk(clk), .cycle_count_rst(rst), .bus(a_if.slave)
  );
  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SATURATE(0)) u_b (
    .clk(clk), .cycle_count_rst(rst), .bus(b_if.slave)
  );
  perf_counter_bank #(.NUM_CH(3), .CNT_W(8), .SATURATE(1)) u_c (
    .clk(clk), .cycle_count_rst(rst), .bus(c_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic        sh;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // One-edge read of instance A; result is valid on return.
  task automatic rd_a(input logic [1:0] sel, input logic sh);
    a_if.rd_sel    = sel;
    a_if.rd_shadow = sh;
    step();
  endtask

  task automatic start_a();
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    a_if.start = 0; a_if.halt = 0; a_if.clear = 0; a_if.snap = 0;
    a_if.evt = '0; a_if.rd_sel = '0; a_if.rd_shadow = 0;
    b_if.start = 0; b_if.halt = 0; b_if.clear = 0; b_if.snap = 0;
    b_if.evt = '0; b_if.rd_sel = '0; b_if.rd_shadow = 0;
    c_if.start = 0; c_if.halt = 0; c_if.clear = 0; c_if.snap = 0;
    c_if.evt = '0; c_if.rd_sel = '0; c_if.rd_shadow = 0;

    vecs[0] = '{"evt ch0 live",   2'd0, 1'b0, 16'd20};
    vecs[1] = '{"evt ch1 live",   2'd1, 1'b0, 16'd10};
    vecs[2] = '{"evt ch2 live",   2'd2, 1'b0, 16'd20};
    vecs[3] = '{"evt sel=NUM_CH", 2'd3, 1'b0, 16'd0};
    vecs[4] = '{"evt ch0 shadow", 2'd0, 1'b1, 16'd0};
    vecs[5] = '{"evt ch2 shadow", 2'd2, 1'b1, 16'd0};
    vecs[6] = '{"evt shadow oob", 2'd3, 1'b1, 16'd0};

    // Reset state
    #12;
    check("reset rd_data", 64'(a_if.rd_data), 64'd0);
    check("reset running", 64'(a_if.running), 64'd0);
    check("reset done",    64'(a_if.done),    64'd0);
    check("reset ovf",     64'(a_if.ovf),     64'd0);
    rst = 1'b0;
    step();

    // Start, 10 plain edges, halt on edge 11, then extra halt cycles
    start_a();
    steps(10);
    a_if.halt = 1'b1;
    step();
    check("halt done",    64'(a_if.done),    64'd1);
    check("halt running", 64'(a_if.running), 64'd0);
    steps(3);
    a_if.halt = 1'b0;
    rd_a(2'd0, 1'b0);
    check("halt ch0", 64'(a_if.rd_data), 64'd11);

    // Event channels: evt[1] toggling, evt[2] and evt[0] held high, 20 edges
    start_a();
    for (int k = 0; k < 20; k++) begin
      a_if.evt  = {1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, 1'b1};
      a_if.halt = (k == 19);
      step();
    end
    a_if.evt  = '0;
    a_if.halt = 1'b0;
    check("evt ovf clear", 64'(a_if.ovf), 64'd0);
    for (int v = 0; v < 7; v++) begin
      rd_a(vecs[v].sel, vecs[v].sh);
      check(vecs[v].name, 64'(a_if.rd_data), 64'(vecs[v].exp));
    end

    // Snapshot at ch0 = 7, then 5 more edges (the last one halting)
    start_a();
    steps(7);
    a_if.snap = 1'b1;
    step();
    a_if.snap = 1'b0;
    steps(3);
    a_if.halt = 1'b1;
    step();
    a_if.halt = 1'b0;
    rd_a(2'd0, 1'b1);
    check("snap shadow ch0", 64'(a_if.rd_data), 64'd7);
    rd_a(2'd0, 1'b0);
    check("snap live ch0", 64'(a_if.rd_data), 64'd12);

    // Simultaneous control events
    a_if.clear = 1'b1;
    step();
    a_if.clear = 1'b0;
    check("clear running", 64'(a_if.running), 64'd0);
    check("clear done",    64'(a_if.done),    64'd0);
    a_if.start = 1'b1; a_if.halt = 1'b1;
    step();
    a_if.start = 1'b0; a_if.halt = 1'b0;
    check("idle start+halt running", 64'(a_if.running), 64'd1);
    steps(3);
    a_if.start = 1'b1; a_if.halt = 1'b1;
    step();
    a_if.start = 1'b0; a_if.halt = 1'b0;
    check("run start+halt done", 64'(a_if.done), 64'd1);
    rd_a(2'd0, 1'b0);
    check("run start+halt ch0", 64'(a_if.rd_data), 64'd3);
    a_if.clear = 1'b1; a_if.start = 1'b1;
    step();
    a_if.clear = 1'b0; a_if.start = 1'b0;
    check("clear+start running", 64'(a_if.running), 64'd0);
    rd_a(2'd0, 1'b0);
    check("clear+start ch0", 64'(a_if.rd_data), 64'd0);

    // Reset in the middle of a run with ch0 = 0x1234
    start_a();
    a_if.rd_sel = 2'd0; a_if.rd_shadow = 1'b0;
    steps(4661);
    check("pre-reset ch0", 64'(a_if.rd_data), 64'h1234);
    #2 rst = 1'b1;
    #1;
    check("async rst rd_data", 64'(a_if.rd_data), 64'd0);
    check("async rst running", 64'(a_if.running), 64'd0);
    #2 rst = 1'b0;
    steps(5);
    rd_a(2'd0, 1'b0);
    check("post-reset ch0",      64'(a_if.rd_data), 64'd0);
    check("post-reset running",  64'(a_if.running), 64'd0);

    // 8-bit overflow: wrap (B) versus saturate (C) over 257 counting edges
    b_if.start = 1'b1; c_if.start = 1'b1;
    step();
    b_if.start = 1'b0; c_if.start = 1'b0;
    for (int k = 0; k < 257; k++) begin
      b_if.halt = (k == 256);
      c_if.halt = (k == 256);
      step();
    end
    b_if.halt = 1'b0; c_if.halt = 1'b0;
    step();
    check("wrap ch0",     64'(b_if.rd_data), 64'd1);
    check("wrap ovf",     64'(b_if.ovf),     64'b001);
    check("sat ch0",      64'(c_if.rd_data), 64'hFF);
    check("sat ovf",      64'(c_if.ovf),     64'b001);
    b_if.start = 1'b1; c_if.start = 1'b1;
    step();
    b_if.start = 1'b0; c_if.start = 1'b0;
    check("wrap ovf after start", 64'(b_if.ovf), 64'd0);
    check("sat ovf after start",  64'(c_if.ovf), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
